// File: rtl/fp_mult_pkg.sv
// Shared encodings and parameter helpers for the sequential Booth floating-point multiplier.
package fp_mult_pkg;

  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t UNPACK = 3'd1;
  localparam state_t MULT   = 3'd2;
  localparam state_t NORM   = 3'd3;
  localparam state_t ROUND  = 3'd4;
  localparam state_t DONE   = 3'd5;

  typedef logic [2:0] booth_sel_t;
  localparam booth_sel_t ZERO = 3'd0;
  localparam booth_sel_t POS1 = 3'd1;
  localparam booth_sel_t POS2 = 3'd2;
  localparam booth_sel_t NEG1 = 3'd3;
  localparam booth_sel_t NEG2 = 3'd4;

  function automatic int unsigned bias_f(int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned iter_f(int unsigned man_w);
    return (man_w + 3) / 2;
  endfunction

  function automatic logic [63:0] qnan_f(int unsigned exp_w, int unsigned man_w);
    logic [63:0] e_ones;
    e_ones = (64'd1 << exp_w) - 64'd1;
    return (e_ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_booth_mult_if.sv
// Operand/result valid-ready bus of the floating-point multiplier.
interface fp_booth_mult_if #(
  parameter int unsigned W = 16
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;

  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, out);
  modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, out);
endinterface

// File: rtl/booth_r4_pp.sv
// Radix-4 Booth recoder: 3-bit multiplier window to a signed partial product of the multiplicand.
module booth_r4_pp import fp_mult_pkg::*; #(
  parameter int unsigned M = 8
) (
  input  logic [2:0]          win_i,
  input  logic [M-1:0]        mcand_i,
  output logic signed [M+1:0] pp_o
);
  booth_sel_t   sel;
  logic [M+1:0] one_x;
  logic [M+1:0] two_x;

  always_comb begin
    unique case (win_i)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
  end

  always_comb begin
    one_x = {2'b00, mcand_i};
    two_x = {1'b0, mcand_i, 1'b0};
    unique case (sel)
      POS1:    pp_o = one_x;
      POS2:    pp_o = two_x;
      NEG1:    pp_o = -one_x;
      NEG2:    pp_o = -two_x;
      default: pp_o = '0;
    endcase
  end
endmodule

// File: rtl/fp_booth_mult.sv
// Sequential IEEE-style multiplier: radix-4 Booth mantissa loop, normalise, RNE round, specials.
module fp_booth_mult import fp_mult_pkg::*; #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 7,
  parameter int unsigned W     = EXP_W + MAN_W + 1
) (
  input  logic           clk,
  input  logic           reset,
  fp_booth_mult_if.slave bus
);
  localparam int unsigned M    = MAN_W + 1;
  localparam int unsigned ITER = iter_f(MAN_W);
  localparam int unsigned SH   = 2 * ITER - M;
  localparam int unsigned AW   = 2 * M + 2;
  localparam int unsigned BW   = 2 * ITER + 1;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam int unsigned XW   = EXP_W + 2;
  localparam logic signed [XW-1:0] BIAS    = XW'(bias_f(EXP_W));
  localparam logic signed [XW-1:0] EXP_MAX = XW'((32'd1 << EXP_W) - 32'd1);
  localparam logic [W-1:0]         QNAN    = W'(qnan_f(EXP_W, MAN_W));

  state_t               state_q, state_d;
  logic                 in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [W-1:0]         out_q, out_d, a_q, a_d, b_q, b_d;
  logic                 sign_q, sign_d, spec_q, spec_d, lost_q, lost_d;
  logic signed [XW-1:0] exp_q, exp_d;
  logic [M-1:0]         ma_q, ma_d, man_q, man_d;
  logic [BW-1:0]        mult_q, mult_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           grs_q, grs_d;

  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [M+1:0]  pp;
  logic [AW-1:0]        sum;
  logic [2*M-1:0]       prod;
  logic                 rnd_up;
  logic [M:0]           man_r;
  logic signed [XW-1:0] exp_r;
  logic [MAN_W-1:0]     frac_r;
  logic                 unused_acc;

  assign ea     = a_q[W-2:MAN_W];
  assign eb     = b_q[W-2:MAN_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  booth_r4_pp #(.M(M)) u_pp (
    .win_i   (mult_q[2:0]),
    .mcand_i (ma_q),
    .pp_o    (pp)
  );

  // Partial product enters at the top; the two bits shifted out each cycle are final product bits.
  assign sum        = acc_q + {pp, {M{1'b0}}};
  assign prod       = {acc_q[2*M-1-SH:0], {SH{1'b0}}};
  assign unused_acc = ^acc_q[AW-1:2*M-SH];

  assign rnd_up = grs_q[2] & (grs_q[1] | grs_q[0] | man_q[0]);
  assign man_r  = {1'b0, man_q} + {{M{1'b0}}, rnd_up};
  assign exp_r  = exp_q + {{(XW-1){1'b0}}, man_r[M]};
  assign frac_r = man_r[M] ? man_r[M-1:1] : man_r[MAN_W-1:0];

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    spec_d  = spec_q;
    lost_d  = lost_q;
    exp_d   = exp_q;
    ma_d    = ma_q;
    man_d   = man_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    grs_d   = grs_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d = a_q[W-1] ^ b_q[W-1];
        exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
        ma_d   = {1'b1, fa};
        mult_d = {{SH{1'b0}}, 1'b1, fb, 1'b0};
        acc_d  = '0;
        cnt_d  = '0;
        lost_d = 1'b0;
        spec_d = 1'b1;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
          out_d = QNAN;
        end else if (a_inf || b_inf) begin
          out_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
          out_d = {sign_d, {(W-1){1'b0}}};
        end else begin
          spec_d = 1'b0;
        end
        // Specials pass through ROUND untouched so they land two edges after accept.
        state_d = spec_d ? ROUND : MULT;
      end
      MULT: begin
        acc_d  = $signed(sum) >>> 2;
        lost_d = lost_q | (|sum[1:0]);
        mult_d = mult_q >> 2;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = NORM;
      end
      NORM: begin
        if (prod[2*M-1]) begin
          man_d = prod[2*M-1:M];
          grs_d = {prod[M-1], prod[M-2], (|prod[M-3:0]) | lost_q};
          exp_d = exp_q + {{(XW-1){1'b0}}, 1'b1};
        end else begin
          man_d = prod[2*M-2:M-1];
          grs_d = {prod[M-2], prod[M-3], (|prod[M-4:0]) | lost_q};
        end
        state_d = ROUND;
      end
      ROUND: begin
        if (!spec_q) begin
          if (exp_r >= EXP_MAX) begin
            out_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          end else if (exp_r[XW-1] || (exp_r == '0)) begin
            out_d = {sign_q, {(W-1){1'b0}}};
          end else begin
            out_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
          end
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      spec_q      <= 1'b0;
      lost_q      <= 1'b0;
      exp_q       <= '0;
      ma_q        <= '0;
      man_q       <= '0;
      mult_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      grs_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      spec_q      <= spec_d;
      lost_q      <= lost_d;
      exp_q       <= exp_d;
      ma_q        <= ma_d;
      man_q       <= man_d;
      mult_q      <= mult_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      grs_q       <= grs_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
endmodule

// File: tb/tb_fp_booth_mult.sv
// Directed bench for fp_booth_mult: bf16 vector table, backpressure, async reset, fp32 build.
module tb_fp_booth_mult;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_booth_mult_if #(.W(16)) b16 ();
  fp_booth_mult_if #(.W(32)) b32 ();

  fp_booth_mult #(.EXP_W(8), .MAN_W(7)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (b16)
  );

  fp_booth_mult #(.EXP_W(8), .MAN_W(23)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (b32)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    int          lat;
  } vec_t;

  vec_t vecs[15];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Called #1 after a rising edge; returns edges from accept to out_valid.
  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, output logic [15:0] res,
                      output int lat, output logic ir_seen);
    int n;
    n = 0;
    while (!b16.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    b16.a        = ta;
    b16.b        = tb;
    b16.in_valid = 1'b1;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    lat     = 0;
    ir_seen = b16.in_ready;
    while (!b16.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      ir_seen = ir_seen | b16.in_ready;
    end
    res = b16.out;
  endtask

  task automatic release16();
    b16.out_ready = 1'b1;
    @(posedge clk); #1;
    b16.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] res;
    int          lat;
    logic        ir_seen;
    logic        bp_bad;

    vecs[0]  = '{16'h3FC0, 16'h4000, 16'h4040, 8};
    vecs[1]  = '{16'hBF80, 16'h3F80, 16'hBF80, 8};
    vecs[2]  = '{16'h3F81, 16'h3F81, 16'h3F82, 8};
    vecs[3]  = '{16'h3FC0, 16'h3FC0, 16'h4010, 8};
    vecs[4]  = '{16'h3F81, 16'h3FC0, 16'h3FC2, 8};
    vecs[5]  = '{16'h3F83, 16'h3FC0, 16'h3FC4, 8};
    vecs[6]  = '{16'h3FB4, 16'h3FB6, 16'h4000, 8};
    vecs[7]  = '{16'hC000, 16'hC040, 16'h40C0, 8};
    vecs[8]  = '{16'h7F80, 16'h0000, 16'h7FC0, 2};
    vecs[9]  = '{16'hFF80, 16'h4000, 16'hFF80, 2};
    vecs[10] = '{16'h0001, 16'h3F80, 16'h0000, 2};
    vecs[11] = '{16'h7F00, 16'h4000, 16'h7F80, 8};
    vecs[12] = '{16'h0080, 16'h0080, 16'h0000, 8};
    vecs[13] = '{16'h7FC1, 16'h3F80, 16'h7FC0, 2};
    vecs[14] = '{16'h8000, 16'h3F80, 16'h8000, 2};

    reset         = 1'b0;
    b16.in_valid  = 1'b0;
    b16.out_ready = 1'b0;
    b16.a         = '0;
    b16.b         = '0;
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b0;
    b32.a         = '0;
    b32.b         = '0;
    #1;
    check("rst_out_valid", b16.out_valid, 0);
    check("rst_in_ready", b16.in_ready, 0);
    check("rst_out", b16.out, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check("rel_in_ready_pre_edge", b16.in_ready, 0);
    @(posedge clk); #1;
    check("rel_in_ready", b16.in_ready, 1);

    for (int i = 0; i < 15; i++) begin
      op16(vecs[i].a, vecs[i].b, res, lat, ir_seen);
      check($sformatf("vec%0d_out", i), res, vecs[i].y);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_in_ready_busy", i), ir_seen, 0);
      release16();
    end

    // Backpressure: hold the result for 20 cycles.
    op16(16'h3FC0, 16'h4000, res, lat, ir_seen);
    check("bp_out", res, 16'h4040);
    bp_bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!b16.out_valid || b16.out !== 16'h4040 || b16.in_ready) bp_bad = 1'b1;
    end
    check("bp_hold", bp_bad, 0);
    release16();
    check("bp_rel_in_ready", b16.in_ready, 1);
    check("bp_rel_out_valid", b16.out_valid, 0);

    // Asynchronous reset while in MULT.
    b16.a        = 16'h3FC0;
    b16.b        = 16'h4000;
    b16.in_valid = 1'b1;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("arst_out_valid", b16.out_valid, 0);
    check("arst_in_ready", b16.in_ready, 0);
    check("arst_out", b16.out, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("arst_rel_in_ready", b16.in_ready, 1);
    check("arst_no_stale_valid", b16.out_valid, 0);
    op16(16'h3FC0, 16'h4000, res, lat, ir_seen);
    check("arst_next_out", res, 16'h4040);
    check("arst_next_latency", lat, 8);
    release16();

    // Single-precision build.
    b32.a        = 32'h3FC00000;
    b32.b        = 32'h40000000;
    b32.in_valid = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    lat = 0;
    while (!b32.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("fp32_out", b32.out, 32'h40400000);
    check("fp32_latency", lat, 16);
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    check("fp32_rel_in_ready", b32.in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
